// File: rtl/ballot_controller.sv
// ballot_controller: sequences one voter's session on the EVM ballot unit.
// Officer arm edge -> accept exactly one clean candidate press -> hand the
// choice to the tally over valid/ack -> light the confirm LED -> relock.
// Optional feature: define BALLOT_TIMEOUT_EN to drop an unused ARMED session
// back to IDLE after TIMEOUT_CYCLES cycles without an accepted press.
module ballot_controller #(
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned VCNT_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        btn,
    input  logic              arm,
    input  logic              close,
    input  logic              tally_ack,
    output logic              vote_valid,
    output logic [1:0]        vote_idx,
    output logic [3:0]        led,
    output logic [2:0]        rgb,
    output logic [VCNT_W-1:0] voter_cnt,
    output logic              poll_closed
);

    localparam int unsigned CW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

    localparam logic [2:0] RgbIdle    = 3'b001;
    localparam logic [2:0] RgbArmed   = 3'b010;
    localparam logic [2:0] RgbConfirm = 3'b100;
    localparam logic [2:0] RgbClosed  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StSend,
        StConfirm,
        StClosed
    } state_t;

    state_t          state;
    logic [3:0]      btn_q;
    logic            arm_q;
    logic            close_pend;
    logic [CW-1:0]   timer;

`ifdef BALLOT_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]   tmo;
`endif

    logic            btn_onehot;
    logic            press;
    logic            arm_rise;
    logic [1:0]      btn_enc;
    logic            vote_done;
    logic            go_close;
    logic [VCNT_W-1:0] cnt_inc;

    function automatic logic [3:0] idx_to_led(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // A press only counts when exactly one button is down and all were up last cycle.
    assign btn_onehot = (btn != 4'b0000) && ((btn & (btn - 4'd1)) == 4'b0000);
    assign press      = btn_onehot && (btn_q == 4'b0000);
    assign arm_rise   = arm && !arm_q;
    assign vote_done  = (state == StSend) && tally_ack;
    assign cnt_inc    = (voter_cnt == {VCNT_W{1'b1}}) ? voter_cnt : voter_cnt + 1'b1;

    // Encode the single pressed button into a candidate index.
    always_comb begin
        btn_enc = 2'd0;
        case (btn)
            4'b0010: btn_enc = 2'd1;
            4'b0100: btn_enc = 2'd2;
            4'b1000: btn_enc = 2'd3;
            default: btn_enc = 2'd0;
        endcase
    end

    // Poll close wins everywhere except an open handshake, which must finish first.
    always_comb begin
        go_close = 1'b0;
        case (state)
            StIdle, StArmed, StConfirm: go_close = close;
            StSend:                     go_close = tally_ack && (close || close_pend);
            default:                    go_close = 1'b0;
        endcase
    end

    // Edge-detect history for the buttons and the officer arm switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 4'hF;
            arm_q <= 1'b0;
        end else begin
            btn_q <= btn;
            arm_q <= arm;
        end
    end

    // Session state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            vote_valid  <= 1'b0;
            vote_idx    <= 2'd0;
            led         <= 4'b0000;
            rgb         <= RgbIdle;
            voter_cnt   <= '0;
            poll_closed <= 1'b0;
            close_pend  <= 1'b0;
            timer       <= '0;
`ifdef BALLOT_TIMEOUT_EN
            tmo         <= '0;
`endif
        end else begin
            if (vote_done) begin
                voter_cnt <= cnt_inc;
            end
            if (go_close) begin
                state       <= StClosed;
                vote_valid  <= 1'b0;
                led         <= 4'b0000;
                rgb         <= RgbClosed;
                poll_closed <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (arm_rise) begin
                            state <= StArmed;
                            rgb   <= RgbArmed;
`ifdef BALLOT_TIMEOUT_EN
                            tmo   <= '0;
`endif
                        end
                    end
                    StArmed: begin
                        if (press) begin
                            state      <= StSend;
                            vote_idx   <= btn_enc;
                            vote_valid <= 1'b1;
                            led        <= idx_to_led(btn_enc);
                            close_pend <= 1'b0;
                        end
`ifdef BALLOT_TIMEOUT_EN
                        // A press on the final cycle is taken above before timing out.
                        else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                            state <= StIdle;
                            rgb   <= RgbIdle;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
`endif
                    end
                    StSend: begin
                        if (tally_ack) begin
                            state      <= StConfirm;
                            vote_valid <= 1'b0;
                            rgb        <= RgbConfirm;
                            timer      <= CW'(CONFIRM_CYCLES - 1);
                        end else if (close) begin
                            // Remember a close seen mid-handshake; honoured at ack.
                            close_pend <= 1'b1;
                        end
                    end
                    StConfirm: begin
                        if (timer == '0) begin
                            state <= StIdle;
                            led   <= 4'b0000;
                            rgb   <= RgbIdle;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    StClosed: begin
                        state <= StClosed;
                    end
                    default: begin
                        state      <= StIdle;
                        vote_valid <= 1'b0;
                        led        <= 4'b0000;
                        rgb        <= RgbIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: hand-derived vector table for the
// main sessions, then model-checked sequences, saturation and random stimulus.
module tb_ballot_controller;

    localparam int unsigned CONFIRM_CYCLES = 4;
    localparam int unsigned VCNT_W         = 8;
    localparam int unsigned TIMEOUT_CYCLES = 32;
    localparam logic [18:0] RESET_OBS      = {1'b0, 2'd0, 4'b0000, 3'b001, 8'd0, 1'b0};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [3:0]        btn = 4'b0000;
    logic              arm = 1'b0;
    logic              close = 1'b0;
    logic              tally_ack = 1'b0;
    logic              vote_valid;
    logic [1:0]        vote_idx;
    logic [3:0]        led;
    logic [2:0]        rgb;
    logic [VCNT_W-1:0] voter_cnt;
    logic              poll_closed;
    logic [18:0]       obs;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    ballot_controller #(
        .CONFIRM_CYCLES(CONFIRM_CYCLES),
        .VCNT_W        (VCNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .arm        (arm),
        .close      (close),
        .tally_ack  (tally_ack),
        .vote_valid (vote_valid),
        .vote_idx   (vote_idx),
        .led        (led),
        .rgb        (rgb),
        .voter_cnt  (voter_cnt),
        .poll_closed(poll_closed)
    );

    always #5 clk = ~clk;

    assign obs = {vote_valid, vote_idx, led, rgb, voter_cnt, poll_closed};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_armed, m_sending, m_closed, m_close_seen;
    int         m_confirm_left, m_tmo, m_cnt;
    logic [1:0] m_idx;
    logic [3:0] m_prev_btn;
    logic       m_prev_arm;

    function automatic void model_reset();
        m_armed = 0; m_sending = 0; m_closed = 0; m_close_seen = 0;
        m_confirm_left = 0; m_tmo = 0; m_cnt = 0; m_idx = 2'd0;
        m_prev_btn = 4'hF; m_prev_arm = 1'b0;
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] b);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (b[i]) r = 2'(i);
        return r;
    endfunction

    function automatic void model_step(input logic [3:0] b, input logic a, input logic c,
                                       input logic k);
        bit press;
        press = ($countones(b) == 1) && (m_prev_btn == 4'b0000);
        if (m_closed) begin
        end else if (m_sending) begin
            if (k) begin
                m_sending = 0;
                if (m_cnt < (1 << VCNT_W) - 1) m_cnt++;
                if (c || m_close_seen) m_closed = 1;
                else m_confirm_left = CONFIRM_CYCLES;
            end else if (c) begin
                m_close_seen = 1;
            end
        end else if (c) begin
            m_closed = 1; m_armed = 0; m_confirm_left = 0;
        end else if (m_confirm_left > 0) begin
            m_confirm_left--;
        end else if (m_armed) begin
            if (press) begin
                m_armed = 0; m_sending = 1; m_idx = idx_of(b);
            end
`ifdef BALLOT_TIMEOUT_EN
            else begin
                m_tmo++;
                if (m_tmo == TIMEOUT_CYCLES) m_armed = 0;
            end
`endif
        end else if (a && !m_prev_arm) begin
            m_armed = 1; m_tmo = 0;
        end
        m_prev_btn = b;
        m_prev_arm = a;
    endfunction

    function automatic logic [18:0] model_exp();
        logic [3:0] l;
        logic [2:0] c;
        l = 4'b0000;
        if (!m_closed && (m_sending || m_confirm_left > 0)) l[m_idx] = 1'b1;
        if (m_closed) c = 3'b111;
        else if (m_confirm_left > 0) c = 3'b100;
        else if (m_armed || m_sending) c = 3'b010;
        else c = 3'b001;
        return {m_sending, m_idx, l, c, 8'(m_cnt), m_closed};
    endfunction

    // One clock with the given inputs, compared against the model.
    task automatic cycle(input logic [3:0] b, input logic a, input logic c, input logic k);
        btn = b; arm = a; close = c; tally_ack = k;
        @(posedge clk);
        model_step(b, a, c, k);
        #1;
        cyc_no++;
        check($sformatf("model_cyc%0d", cyc_no), obs, model_exp());
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        btn = 4'b0000; arm = 1'b0; close = 1'b0; tally_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("async_reset", obs, RESET_OBS);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  b;
        logic        a, c, k;
        logic [18:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [3:0] b, input logic a, input logic c, input logic k,
                                input logic v, input logic [1:0] idx, input logic [3:0] l,
                                input logic [2:0] col, input logic [7:0] cnt, input logic pc);
        vec_t r;
        r.b = b; r.a = a; r.c = c; r.k = k;
        r.exp = {v, idx, l, col, cnt, pc};
        vecs.push_back(r);
    endfunction

    initial begin
        logic [3:0] rb;
        logic       ra, rc, rk;
        int         r;

        // Vote for b2 with ack on the second valid cycle, then LED hold and relock.
        add(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 3'b010, 8'd0, 0);
        add(4'b0010, 0, 0, 0, 1, 2'd1, 4'b0010, 3'b010, 8'd0, 0);
        add(4'b0000, 0, 0, 0, 1, 2'd1, 4'b0010, 3'b010, 8'd0, 0);
        add(4'b0000, 0, 0, 1, 0, 2'd1, 4'b0010, 3'b100, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0010, 3'b100, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0010, 3'b100, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0010, 3'b100, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b001, 8'd1, 0);
        // Press without arm ignored; multi-press ignored; release then b4.
        add(4'b0001, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b001, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b001, 8'd1, 0);
        add(4'b0000, 1, 0, 0, 0, 2'd1, 4'b0000, 3'b010, 8'd1, 0);
        add(4'b0101, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b010, 8'd1, 0);
        add(4'b0101, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b010, 8'd1, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd1, 4'b0000, 3'b010, 8'd1, 0);
        add(4'b1000, 0, 0, 0, 1, 2'd3, 4'b1000, 3'b010, 8'd1, 0);
        add(4'b0000, 0, 0, 1, 0, 2'd3, 4'b1000, 3'b100, 8'd2, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd3, 4'b1000, 3'b100, 8'd2, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd3, 4'b1000, 3'b100, 8'd2, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd3, 4'b1000, 3'b100, 8'd2, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000, 3'b001, 8'd2, 0);
        // Button held through the arm rise: only a re-press counts.
        add(4'b0100, 0, 0, 0, 0, 2'd3, 4'b0000, 3'b001, 8'd2, 0);
        add(4'b0100, 1, 0, 0, 0, 2'd3, 4'b0000, 3'b010, 8'd2, 0);
        add(4'b0100, 0, 0, 0, 0, 2'd3, 4'b0000, 3'b010, 8'd2, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd3, 4'b0000, 3'b010, 8'd2, 0);
        add(4'b0100, 0, 0, 0, 1, 2'd2, 4'b0100, 3'b010, 8'd2, 0);
        add(4'b0000, 0, 0, 1, 0, 2'd2, 4'b0100, 3'b100, 8'd3, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0100, 3'b100, 8'd3, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0100, 3'b100, 8'd3, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0100, 3'b100, 8'd3, 0);
        add(4'b0000, 0, 0, 0, 0, 2'd2, 4'b0000, 3'b001, 8'd3, 0);
        // Close during SEND: handshake completes, count bumps, then CLOSED for good.
        add(4'b0000, 1, 0, 0, 0, 2'd2, 4'b0000, 3'b010, 8'd3, 0);
        add(4'b0001, 0, 0, 0, 1, 2'd0, 4'b0001, 3'b010, 8'd3, 0);
        add(4'b0000, 0, 1, 0, 1, 2'd0, 4'b0001, 3'b010, 8'd3, 0);
        add(4'b0000, 0, 1, 0, 1, 2'd0, 4'b0001, 3'b010, 8'd3, 0);
        add(4'b0000, 0, 1, 0, 1, 2'd0, 4'b0001, 3'b010, 8'd3, 0);
        add(4'b0000, 0, 1, 1, 0, 2'd0, 4'b0000, 3'b111, 8'd4, 1);
        add(4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 3'b111, 8'd4, 1);
        add(4'b0010, 0, 0, 0, 0, 2'd0, 4'b0000, 3'b111, 8'd4, 1);
        add(4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000, 3'b111, 8'd4, 1);

        #2;
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            btn = vecs[i].b; arm = vecs[i].a; close = vecs[i].c; tally_ack = vecs[i].k;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Reset while a vote is on offer: it is discarded, count clears.
        do_reset();
        cycle(4'b0000, 1, 0, 0);
        cycle(4'b0010, 0, 0, 0);
        cycle(4'b0000, 0, 0, 1);
        repeat (CONFIRM_CYCLES) cycle(4'b0000, 0, 0, 0);
        cycle(4'b0000, 1, 0, 0);
        cycle(4'b0100, 0, 0, 0);
        check("valid_before_reset", {31'd0, vote_valid}, 32'd1);
        do_reset();

        // Close wins over a same-cycle arm edge in IDLE.
        cycle(4'b0000, 1, 1, 0);
        check("close_over_arm", {29'd0, rgb}, 32'h7);
        do_reset();

        // ARMED with no press.
        cycle(4'b0000, 1, 0, 0);
        repeat (TIMEOUT_CYCLES - 1) cycle(4'b0000, 0, 0, 0);
        check("armed_last_cycle", {29'd0, rgb}, 32'h2);
        cycle(4'b0000, 0, 0, 0);
`ifdef BALLOT_TIMEOUT_EN
        check("timeout_idle", {29'd0, rgb}, 32'h1);
        check("timeout_no_vote", {31'd0, vote_valid}, 32'd0);
        // Press on the final ARMED cycle beats the timeout.
        cycle(4'b0000, 1, 0, 0);
        repeat (TIMEOUT_CYCLES - 1) cycle(4'b0000, 0, 0, 0);
        cycle(4'b1000, 0, 0, 0);
        check("press_beats_timeout", {31'd0, vote_valid}, 32'd1);
`else
        repeat (8) cycle(4'b0000, 0, 0, 0);
        check("armed_waits", {29'd0, rgb}, 32'h2);
`endif

        // Counter saturation after 256 accepted ballots.
        do_reset();
        for (int v = 0; v < 256; v++) begin
            cycle(4'b0000, 1, 0, 0);
            cycle(4'b0001 << (v % 4), 0, 0, 0);
            cycle(4'b0000, 0, 0, 1);
            repeat (CONFIRM_CYCLES) cycle(4'b0000, 0, 0, 0);
        end
        check("saturate", {24'd0, voter_cnt}, 32'd255);

        // Randomized stimulus against the model.
        ra = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            if (it % 500 == 0) begin
                do_reset();
                ra = 1'b0;
            end
            r = int'($urandom_range(0, 7));
            if (r < 4) rb = 4'b0000;
            else if (r < 6) rb = 4'b0001 << $urandom_range(0, 3);
            else if (r == 6) rb = 4'($urandom);
            else rb = btn;
            if ($urandom_range(0, 99) < 15) ra = ~ra;
            rc = ($urandom_range(0, 299) == 0);
            rk = ($urandom_range(0, 9) < 4);
            cycle(rb, ra, rc, rk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
